// File: rtl/csr_file_if.sv
// Bundles the decode read port, execute writeback/trap commit signals and the
// registered redirect outputs of the machine-mode CSR file.
interface csr_file_if;
    logic [11:0] csr_rd_adr_i;
    logic        csr_rd_we_i;
    logic [31:0] csr_rd_data_o;
    logic        csr_illegal_o;

    logic        csr_wbk_v_i;
    logic [11:0] csr_adr_i;
    logic [31:0] csr_data_i;

    logic        exception_i;
    logic [31:0] mcause_i;
    logic [31:0] mtval_i;
    logic [31:0] mepc_i;
    logic        mret_i;
    logic [1:0]  core_mode_i;
    logic        retire_v_i;

    logic [31:0] mtvec_q_o;
    logic [31:0] mepc_q_o;
    logic [31:0] mstatus_q_o;

    modport master (
        output csr_rd_adr_i, csr_rd_we_i, csr_wbk_v_i, csr_adr_i, csr_data_i,
               exception_i, mcause_i, mtval_i, mepc_i, mret_i, core_mode_i,
               retire_v_i,
        input  csr_rd_data_o, csr_illegal_o, mtvec_q_o, mepc_q_o, mstatus_q_o
    );

    modport slave (
        input  csr_rd_adr_i, csr_rd_we_i, csr_wbk_v_i, csr_adr_i, csr_data_i,
               exception_i, mcause_i, mtval_i, mepc_i, mret_i, core_mode_i,
               retire_v_i,
        output csr_rd_data_o, csr_illegal_o, mtvec_q_o, mepc_q_o, mstatus_q_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR storage: commits execute's CSR writes and trap/mret state,
// serves a combinational read port to decode and runs mcycle/minstret.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset,
    csr_file_if.slave bus
);

    localparam logic [11:0] ADR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADR_MISA      = 12'h301;
    localparam logic [11:0] ADR_MIE       = 12'h304;
    localparam logic [11:0] ADR_MTVEC     = 12'h305;
    localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADR_MEPC      = 12'h341;
    localparam logic [11:0] ADR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADR_MTVAL     = 12'h343;
    localparam logic [11:0] ADR_MIP       = 12'h344;
    localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
    localparam logic [31:0] MTVEC_RST_VAL = {MTVEC_RESET[31:2], 2'b00};

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [1:0]  mpp_q, mpp_d;
    logic [31:0] mie_reg_q, mie_reg_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] mstatus_q;
    logic [31:0] wdata;
    logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc;
    logic        wr_mcause, wr_mtval;
    logic        wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

    assign mstatus_q = {19'd0, mpp_q, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
    assign wdata     = bus.csr_data_i;

    assign wr_mstatus   = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MSTATUS);
    assign wr_mie       = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MIE);
    assign wr_mtvec     = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MTVEC);
    assign wr_mscratch  = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MSCRATCH);
    assign wr_mepc      = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MEPC);
    assign wr_mcause    = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MCAUSE);
    assign wr_mtval     = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MTVAL);
    assign wr_mcycle    = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MCYCLE);
    assign wr_mcycleh   = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MCYCLEH);
    assign wr_minstret  = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MINSTRET);
    assign wr_minstreth = bus.csr_wbk_v_i && (bus.csr_adr_i == ADR_MINSTRETH);

    // Trap beats mret beats CSR write, decided per register.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mpp_d      = mpp_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mie_reg_d  = wr_mie      ? (wdata & MIE_MASK)      : mie_reg_q;
        mtvec_d    = wr_mtvec    ? {wdata[31:2], 2'b00}    : mtvec_q;
        mscratch_d = wr_mscratch ? wdata                   : mscratch_q;

        if (bus.exception_i) begin
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = bus.core_mode_i;
            mepc_d   = {bus.mepc_i[31:2], 2'b00};
            mcause_d = bus.mcause_i;
            mtval_d  = bus.mtval_i;
        end else begin
            if (bus.mret_i) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
                mpp_d  = 2'b00;
            end else if (wr_mstatus) begin
                mie_d  = wdata[3];
                mpie_d = wdata[7];
                if (wdata[12:11] != 2'b10) begin
                    mpp_d = wdata[12:11];
                end
            end
            if (wr_mepc) begin
                mepc_d = {wdata[31:2], 2'b00};
            end
            if (wr_mcause) begin
                mcause_d = wdata;
            end
            if (wr_mtval) begin
                mtval_d = wdata;
            end
        end
    end

    // A half-write replaces that half only and skips the increment entirely.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.retire_v_i};
        if (wr_mcycle) begin
            mcycle_d = {mcycle_q[63:32], wdata};
        end else if (wr_mcycleh) begin
            mcycle_d = {wdata, mcycle_q[31:0]};
        end
        if (wr_minstret) begin
            minstret_d = {minstret_q[63:32], wdata};
        end else if (wr_minstreth) begin
            minstret_d = {wdata, minstret_q[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= 2'b11;
            mie_reg_q  <= 32'd0;
            mtvec_q    <= MTVEC_RST_VAL;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mpp_q      <= mpp_d;
            mie_reg_q  <= mie_reg_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    logic [31:0] rd_data;
    logic        rd_implemented;

    always_comb begin
        rd_data        = 32'd0;
        rd_implemented = 1'b1;
        case (bus.csr_rd_adr_i)
            ADR_MSTATUS:                 rd_data = mstatus_q;
            ADR_MISA:                    rd_data = MISA_VALUE;
            ADR_MIE:                     rd_data = mie_reg_q;
            ADR_MTVEC:                   rd_data = mtvec_q;
            ADR_MSCRATCH:                rd_data = mscratch_q;
            ADR_MEPC:                    rd_data = mepc_q;
            ADR_MCAUSE:                  rd_data = mcause_q;
            ADR_MTVAL:                   rd_data = mtval_q;
            ADR_MIP:                     rd_data = 32'd0;
            ADR_MCYCLE, ADR_CYCLE:       rd_data = mcycle_q[31:0];
            ADR_MCYCLEH, ADR_CYCLEH:     rd_data = mcycle_q[63:32];
            ADR_MINSTRET, ADR_INSTRET:   rd_data = minstret_q[31:0];
            ADR_MINSTRETH, ADR_INSTRETH: rd_data = minstret_q[63:32];
            ADR_MHARTID:                 rd_data = HART_ID;
            default:                     rd_implemented = 1'b0;
        endcase
    end

    assign bus.csr_rd_data_o = rd_data;
    assign bus.csr_illegal_o = !rd_implemented ||
                               (bus.csr_rd_we_i && (bus.csr_rd_adr_i[11:10] == 2'b11));

    assign bus.mtvec_q_o   = mtvec_q;
    assign bus.mepc_q_o    = mepc_q;
    assign bus.mstatus_q_o = mstatus_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus a randomized run
// compared against a field-level reference model of the CSR state.
module tb_csr_file;

    localparam logic [31:0] MTVEC_RESET = 32'h8000_0103;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csr_file_if bus();

    csr_file #(.MTVEC_RESET(MTVEC_RESET), .HART_ID(32'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Address pool: first 18 entries are implemented CSRs, the rest are not.
    localparam int NUM_IMPL = 18;
    localparam logic [11:0] ADDRS [22] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
        12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
        12'hC82, 12'hF14, 12'h7C0, 12'h001, 12'h306, 12'hB03
    };

    // Reference model state, kept as fields and 64-bit counts.
    logic        refMie, refMpie;
    logic [1:0]  refMpp;
    logic [31:0] refIe, refTvec, refScratch, refEpc, refCause, refTval;
    logic [63:0] refCycle, refInstret;

    function automatic logic [31:0] refStatus();
        return (32'(refMpp) << 11) | (32'(refMpie) << 7) | (32'(refMie) << 3);
    endfunction

    function automatic logic [31:0] refRead(input logic [11:0] a);
        case (a)
            12'h300: return refStatus();
            12'h301: return 32'h4000_0100;
            12'h304: return refIe;
            12'h305: return refTvec;
            12'h340: return refScratch;
            12'h341: return refEpc;
            12'h342: return refCause;
            12'h343: return refTval;
            12'hB00, 12'hC00: return refCycle[31:0];
            12'hB80, 12'hC80: return refCycle[63:32];
            12'hB02, 12'hC02: return refInstret[31:0];
            12'hB82, 12'hC82: return refInstret[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic refIllegal(input logic [11:0] a, input logic we);
        logic known = 1'b0;
        for (int i = 0; i < NUM_IMPL; i++) begin
            if (ADDRS[i] == a) known = 1'b1;
        end
        return !known || (we && a >= 12'hC00);
    endfunction

    task automatic refStep();
        logic        wr  = bus.csr_wbk_v_i;
        logic [11:0] a   = bus.csr_adr_i;
        logic [31:0] d   = bus.csr_data_i;
        logic        exc = bus.exception_i;
        logic        ret = bus.mret_i;
        logic        cycWritten = 1'b0;
        logic        insWritten = 1'b0;
        if (reset) begin
            refMie = 0; refMpie = 0; refMpp = 2'd3;
            refIe = 0; refTvec = MTVEC_RESET & ~32'd3; refScratch = 0;
            refEpc = 0; refCause = 0; refTval = 0; refCycle = 0; refInstret = 0;
            return;
        end
        if (exc) begin
            refMpie = refMie; refMie = 0; refMpp = bus.core_mode_i;
            refEpc = bus.mepc_i & ~32'd3; refCause = bus.mcause_i; refTval = bus.mtval_i;
        end else if (ret) begin
            refMie = refMpie; refMpie = 1; refMpp = 2'd0;
        end
        if (wr) begin
            case (a)
                12'h300: if (!exc && !ret) begin
                    refMie = d[3]; refMpie = d[7];
                    if (((d >> 11) & 32'd3) != 32'd2) refMpp = d[12:11];
                end
                12'h304: refIe = d & 32'h888;
                12'h305: refTvec = d & ~32'd3;
                12'h340: refScratch = d;
                12'h341: if (!exc) refEpc = d & ~32'd3;
                12'h342: if (!exc) refCause = d;
                12'h343: if (!exc) refTval = d;
                12'hB00: begin refCycle = (refCycle & 64'hFFFF_FFFF_0000_0000) | 64'(d); cycWritten = 1; end
                12'hB80: begin refCycle = (refCycle & 64'h0000_0000_FFFF_FFFF) | (64'(d) << 32); cycWritten = 1; end
                12'hB02: begin refInstret = (refInstret & 64'hFFFF_FFFF_0000_0000) | 64'(d); insWritten = 1; end
                12'hB82: begin refInstret = (refInstret & 64'h0000_0000_FFFF_FFFF) | (64'(d) << 32); insWritten = 1; end
                default: ;
            endcase
        end
        if (!cycWritten) refCycle = refCycle + 1;
        if (!insWritten && bus.retire_v_i) refInstret = refInstret + 1;
    endtask

    always @(posedge clk) refStep();

    task automatic idle();
        bus.csr_wbk_v_i = 0; bus.csr_adr_i = 0; bus.csr_data_i = 0;
        bus.exception_i = 0; bus.mret_i = 0; bus.retire_v_i = 0;
        bus.mcause_i = 0; bus.mtval_i = 0; bus.mepc_i = 0; bus.core_mode_i = 0;
        bus.csr_rd_we_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] adr, input logic [31:0] data);
        bus.csr_wbk_v_i = 1; bus.csr_adr_i = adr; bus.csr_data_i = data;
        tick();
        bus.csr_wbk_v_i = 0;
    endtask

    task automatic readCsr(input logic [11:0] adr, input logic we,
                           output logic [31:0] data, output logic ill);
        bus.csr_rd_adr_i = adr; bus.csr_rd_we_i = we;
        #1;
        data = bus.csr_rd_data_o; ill = bus.csr_illegal_o;
        bus.csr_rd_we_i = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic ill;
        reset = 1;
        bus.csr_wbk_v_i = 1; bus.csr_adr_i = 12'h340; bus.csr_data_i = 32'hDEAD_BEEF;
        bus.exception_i = 1; bus.mepc_i = 32'h44; bus.mret_i = 1;
        tick(); tick();
        idle();
        checks++; if (bus.mstatus_q_o !== 32'h0000_1800) begin errors++; $display("[TB] FAIL reset_mstatus_q: got %h expected %h", bus.mstatus_q_o, 32'h1800); end
        checks++; if (bus.mtvec_q_o !== 32'h8000_0100) begin errors++; $display("[TB] FAIL reset_mtvec_q: got %h expected %h", bus.mtvec_q_o, 32'h8000_0100); end
        checks++; if (bus.mepc_q_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_mepc_q: got %h expected 0", bus.mepc_q_o); end
        readCsr(12'h300, 0, d, ill);
        checks++; if (d !== 32'h0000_1800 || ill !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_mstatus: got %h/%b expected 00001800/0", d, ill); end
        readCsr(12'h305, 0, d, ill);
        checks++; if (d !== 32'h8000_0100) begin errors++; $display("[TB] FAIL reset_rd_mtvec: got %h expected 80000100", d); end
        readCsr(12'hF14, 0, d, ill);
        checks++; if (d !== 32'd0 || ill !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_mhartid: got %h/%b expected 0/0", d, ill); end
        readCsr(12'h340, 0, d, ill);
        checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_mscratch: got %h expected 0", d); end
        readCsr(12'h7C0, 0, d, ill);
        checks++; if (ill !== 1'b1) begin errors++; $display("[TB] FAIL illegal_unimpl: got %b expected 1", ill); end
        readCsr(12'hC00, 1, d, ill);
        checks++; if (ill !== 1'b1) begin errors++; $display("[TB] FAIL illegal_ro_write: got %b expected 1", ill); end
        reset = 0;
        readCsr(12'hB00, 0, d, ill);
        checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL mcycle_first: got %h expected 0", d); end
        tick();
        readCsr(12'hB00, 0, d, ill);
        checks++; if (d !== 32'd1) begin errors++; $display("[TB] FAIL mcycle_second: got %h expected 1", d); end
    endtask

    task automatic test_mstatus();
        logic [31:0] d; logic ill;
        applyStimulus(12'h300, 32'hFFFF_FFFF);
        readCsr(12'h300, 0, d, ill);
        checks++; if (d !== 32'h0000_1888) begin errors++; $display("[TB] FAIL mstatus_all_ones: got %h expected 00001888", d); end
        applyStimulus(12'h300, 32'h0000_1000);
        checks++; if (bus.mstatus_q_o !== 32'h0000_1800) begin errors++; $display("[TB] FAIL mstatus_mpp_reserved: got %h expected 00001800", bus.mstatus_q_o); end
        applyStimulus(12'h301, 32'd0);
        readCsr(12'h301, 0, d, ill);
        checks++; if (d !== 32'h4000_0100) begin errors++; $display("[TB] FAIL misa_readonly: got %h expected 40000100", d); end
        applyStimulus(12'h304, 32'hFFFF_FFFF);
        readCsr(12'h304, 0, d, ill);
        checks++; if (d !== 32'h0000_0888) begin errors++; $display("[TB] FAIL mie_mask: got %h expected 00000888", d); end
    endtask

    task automatic test_trap();
        logic [31:0] d; logic ill;
        applyStimulus(12'h300, 32'h0000_1808);
        bus.exception_i = 1; bus.mcause_i = 32'd2; bus.mepc_i = 32'h0000_0107;
        bus.mtval_i = 32'h0000_0055; bus.core_mode_i = 2'b00;
        tick();
        idle();
        checks++; if (bus.mepc_q_o !== 32'h0000_0104) begin errors++; $display("[TB] FAIL trap_mepc: got %h expected 00000104", bus.mepc_q_o); end
        readCsr(12'h342, 0, d, ill);
        checks++; if (d !== 32'd2) begin errors++; $display("[TB] FAIL trap_mcause: got %h expected 2", d); end
        readCsr(12'h343, 0, d, ill);
        checks++; if (d !== 32'h55) begin errors++; $display("[TB] FAIL trap_mtval: got %h expected 55", d); end
        checks++; if (bus.mstatus_q_o !== 32'h0000_0080) begin errors++; $display("[TB] FAIL trap_mstatus: got %h expected 00000080", bus.mstatus_q_o); end
        bus.mret_i = 1;
        tick();
        idle();
        checks++; if (bus.mstatus_q_o !== 32'h0000_0088) begin errors++; $display("[TB] FAIL mret_mstatus: got %h expected 00000088", bus.mstatus_q_o); end
    endtask

    task automatic test_priority();
        logic [31:0] d; logic ill;
        bus.exception_i = 1; bus.mepc_i = 32'h0000_0200; bus.mcause_i = 32'd5;
        bus.csr_wbk_v_i = 1; bus.csr_adr_i = 12'h341; bus.csr_data_i = 32'h0000_1234;
        tick();
        idle();
        checks++; if (bus.mepc_q_o !== 32'h0000_0200) begin errors++; $display("[TB] FAIL trap_beats_write: got %h expected 00000200", bus.mepc_q_o); end
        bus.exception_i = 1; bus.mepc_i = 32'h0000_0300; bus.mcause_i = 32'd7;
        bus.csr_wbk_v_i = 1; bus.csr_adr_i = 12'h340; bus.csr_data_i = 32'h0000_CAFE;
        tick();
        idle();
        readCsr(12'h340, 0, d, ill);
        checks++; if (d !== 32'h0000_CAFE) begin errors++; $display("[TB] FAIL trap_plus_mscratch: got %h expected 0000cafe", d); end
        readCsr(12'h342, 0, d, ill);
        checks++; if (d !== 32'd7 || bus.mepc_q_o !== 32'h300) begin errors++; $display("[TB] FAIL trap_plus_mscratch_state: got %h/%h expected 7/300", d, bus.mepc_q_o); end
    endtask

    task automatic test_counters();
        logic [31:0] lo, hi; logic ill;
        applyStimulus(12'hB00, 32'hFFFF_FFFE);
        applyStimulus(12'hB80, 32'd0);
        tick(); tick(); tick();
        readCsr(12'hB00, 0, lo, ill);
        readCsr(12'hB80, 0, hi, ill);
        checks++; if (lo !== 32'd1 || hi !== 32'd1) begin errors++; $display("[TB] FAIL mcycle_carry: got %h/%h expected 1/1", hi, lo); end
        readCsr(12'hC80, 0, hi, ill);
        checks++; if (hi !== 32'd1 || ill !== 1'b0) begin errors++; $display("[TB] FAIL cycleh_alias: got %h/%b expected 1/0", hi, ill); end
    endtask

    task automatic test_minstret();
        logic [31:0] d; logic ill;
        for (int i = 0; i < 5; i++) begin
            bus.retire_v_i = 1;
            if (i == 2) begin
                bus.csr_wbk_v_i = 1; bus.csr_adr_i = 12'hB02; bus.csr_data_i = 32'd100;
            end
            tick();
            bus.csr_wbk_v_i = 0;
        end
        idle();
        readCsr(12'hB02, 0, d, ill);
        checks++; if (d !== 32'd102) begin errors++; $display("[TB] FAIL minstret_write: got %0d expected 102", d); end
        readCsr(12'hC02, 0, d, ill);
        checks++; if (d !== 32'd102) begin errors++; $display("[TB] FAIL instret_alias: got %0d expected 102", d); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic ill;
        logic [11:0] ra; logic rwe;
        for (int n = 0; n < 400; n++) begin
            bus.csr_wbk_v_i = ($urandom_range(0, 1) == 1);
            bus.csr_adr_i   = ADDRS[$urandom_range(0, 21)];
            bus.csr_data_i  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.exception_i = ($urandom_range(0, 7) == 0);
            bus.mret_i      = ($urandom_range(0, 7) == 0);
            bus.retire_v_i  = ($urandom_range(0, 1) == 1);
            bus.mcause_i    = $urandom;
            bus.mtval_i     = $urandom;
            bus.mepc_i      = $urandom;
            bus.core_mode_i = 2'($urandom_range(0, 3));
            if (n % 50 == 0) begin
                bus.csr_adr_i = 12'hB00; bus.csr_data_i = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            end
            tick();
            checks++; if (bus.mstatus_q_o !== refStatus()) begin errors++; $display("[TB] FAIL rand_mstatus_q n=%0d: got %h expected %h", n, bus.mstatus_q_o, refStatus()); end
            checks++; if (bus.mepc_q_o !== refEpc) begin errors++; $display("[TB] FAIL rand_mepc_q n=%0d: got %h expected %h", n, bus.mepc_q_o, refEpc); end
            checks++; if (bus.mtvec_q_o !== refTvec) begin errors++; $display("[TB] FAIL rand_mtvec_q n=%0d: got %h expected %h", n, bus.mtvec_q_o, refTvec); end
            ra  = ADDRS[$urandom_range(0, 21)];
            rwe = ($urandom_range(0, 1) == 1);
            readCsr(ra, rwe, d, ill);
            checks++; if (d !== refRead(ra) || ill !== refIllegal(ra, rwe)) begin
                errors++;
                $display("[TB] FAIL rand_read n=%0d adr=%h: got %h/%b expected %h/%b", n, ra, d, ill, refRead(ra), refIllegal(ra, rwe));
            end
        end
        idle();
    endtask

    initial begin
        reset = 1;
        bus.csr_rd_adr_i = 0;
        idle();
        test_reset();
        test_mstatus();
        test_trap();
        test_priority();
        test_counters();
        test_minstret();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
